// File: rtl/ysyx_25040111_muldiv_if.sv
// Operand/result handshake bundle for the iterative multiply/divide unit.
// Both halves use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer keeps its payload
// stable while valid is high and ready is low.
interface ysyx_25040111_muldiv_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;

    modport master (
        output in_valid, op, src1, src2, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/ysyx_25040111_muldiv.sv
// RV32M iterative multiply/divide unit. Radix-2 shift-add multiplier and
// restoring divider operating on operand magnitudes; signs are reapplied
// when the result is registered. Divide-by-zero and signed overflow bypass
// the iteration and complete in one cycle.
module ysyx_25040111_muldiv #(
    parameter int XLEN = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       flush,
    output logic       busy,
    output logic [1:0] dbg_state,
    ysyx_25040111_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_res;

    logic              w_accept;
    logic              w_is_div;
    logic              w_sgn1;
    logic              w_sgn2;
    logic              w_neg1;
    logic              w_neg2;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_acc;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_acc;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign dbg_state = r_state;
    assign bus.res   = r_res;

    // Decode incoming op: operand signedness, magnitudes, special divides.
    always_comb begin
        w_accept   = bus.in_valid && (r_state == S_IDLE) && !flush;
        w_is_div   = bus.op[2];
        w_sgn1     = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_REM);
        w_sgn2     = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        w_neg1     = w_sgn1 && bus.src1[XLEN-1];
        w_neg2     = w_sgn2 && bus.src2[XLEN-1];
        w_abs1     = w_neg1 ? (~bus.src1 + 1'b1) : bus.src1;
        w_abs2     = w_neg2 ? (~bus.src2 + 1'b1) : bus.src2;
        w_div_zero = w_is_div && (bus.src2 == '0);
        // Only DIV/REM (op[0] clear) can overflow.
        w_div_ovf  = w_is_div && !bus.op[0] && (bus.src1 == MIN_NEG) && (bus.src2 == '1);
        if (w_div_zero) begin
            w_special_res = bus.op[1] ? bus.src1 : '1;
        end else begin
            w_special_res = bus.op[1] ? '0 : bus.src1;
        end
    end

    // One iteration step of each algorithm plus sign fix-up of the final step.
    always_comb begin
        // Multiply: acc = {partial product high, remaining multiplier bits}.
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};
        // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
        w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
        if (w_diff[XLEN+1]) begin
            w_div_acc = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_div_acc = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
        w_acc_nxt = r_op[2] ? w_div_acc : w_mul_acc;
        w_prod    = r_neg_res ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
        w_quo     = r_neg_res ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
        w_rem     = r_neg_rem ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1) : w_acc_nxt[2*XLEN-1:XLEN];
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quo;
        end else if (r_op[1:0] == OP_MUL[1:0]) begin
            w_final = w_prod[XLEN-1:0];
        end else begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = (w_div_zero || w_div_ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, register result.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_res     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.op;
                        r_neg_res <= w_neg1 ^ w_neg2;
                        r_neg_rem <= w_neg1;
                        r_cnt     <= CW'(XLEN - 1);
                        if (w_div_zero || w_div_ovf) begin
                            r_res <= w_special_res;
                        end else begin
                            r_opnd <= w_is_div ? w_abs2 : w_abs1;
                            r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == '0) begin
                        r_res <= w_final;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
